cu_fsm_gen2: RTL and testbench

Multicycle control-unit sequencer for the OTTER RV32I core. It works alongside the combinational CU decoder and supersedes the fixed fetch/execute/writeback FSM. The block is parametrised for memory latency, an optional ready handshake, interrupt support, and an optional M-extension multiply/divide unit with a start/done handshake. It owns the pc_write, reg_write, memory-enable, CSR and interrupt strobes for every instruction.

---
 rtl/cu_fsm_gen2.sv | 125 ++++++++++++
 tb/tb_cu_fsm_gen2.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/cu_fsm_gen2.sv
// cu_fsm_gen2: multicycle OTTER control sequencer with memory wait, mul/div and interrupt handling
module cu_fsm_gen2 #(
    parameter int MEM_HS    = 0,
    parameter int MEM_LAT   = 0,
    parameter int INTR_EN   = 1,
    parameter int MULDIV_EN = 0
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [6:0] opcode,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    input  logic       intr,
    input  logic       mem_rdy,
    input  logic       md_done,
    output logic       pc_write,
    output logic       reg_write,
    output logic       mem_rden1,
    output logic       mem_rden2,
    output logic       mem_we2,
    output logic       csr_we,
    output logic       int_taken,
    output logic       mret_exec,
    output logic       md_start,
    output logic       rst_out
);
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {ST_INIT, ST_FETCH, ST_EXEC, ST_WB, ST_MULDIV, ST_INTR} state_t;

    state_t     state, next;
    logic [3:0] wcnt, wcnt_nx;
    logic       mem_done, done, is_md, is_sys, writes_rd;

    assign mem_done  = (MEM_HS != 0) ? mem_rdy : (wcnt == 4'(MEM_LAT));
    assign is_md     = (MULDIV_EN != 0) && opcode == OP_OP && func7 == 7'b0000001;
    assign is_sys    = opcode == OP_SYSTEM;
    assign writes_rd = opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL ||
                       opcode == OP_JALR || opcode == OP_IMM || opcode == OP_OP;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= ST_INIT;
            wcnt  <= '0;
        end else begin
            state <= next;
            wcnt  <= wcnt_nx;
        end
    end

    always_comb begin
        next      = state;
        wcnt_nx   = '0;
        done      = 1'b0;
        pc_write  = 1'b0;
        reg_write = 1'b0;
        mem_rden1 = 1'b0;
        mem_rden2 = 1'b0;
        mem_we2   = 1'b0;
        csr_we    = 1'b0;
        int_taken = 1'b0;
        mret_exec = 1'b0;
        md_start  = 1'b0;
        rst_out   = 1'b0;
        case (state)
            ST_INIT: begin
                rst_out = 1'b1;
                next    = ST_FETCH;
            end
            ST_FETCH: begin
                mem_rden1 = 1'b1;
                if (mem_done) next = ST_EXEC;
                else wcnt_nx = wcnt + 4'd1;
            end
            ST_EXEC: begin
                if (opcode == OP_LOAD) begin
                    mem_rden2 = 1'b1;
                    next      = ST_WB;
                end else if (opcode == OP_STORE) begin
                    mem_we2  = 1'b1;
                    pc_write = mem_done;
                    done     = mem_done;
                    wcnt_nx  = mem_done ? 4'd0 : wcnt + 4'd1;
                end else if (is_md) begin
                    md_start = 1'b1;
                    next     = ST_MULDIV;
                end else begin
                    // BRANCH and unknown opcodes only advance the PC
                    pc_write  = 1'b1;
                    done      = 1'b1;
                    reg_write = writes_rd || (is_sys && func3 != 3'b000);
                    csr_we    = is_sys && func3 != 3'b000;
                    mret_exec = is_sys && func3 == 3'b000;
                end
            end
            ST_WB: begin
                reg_write = 1'b1;
                pc_write  = mem_done;
                done      = mem_done;
                wcnt_nx   = mem_done ? 4'd0 : wcnt + 4'd1;
            end
            ST_MULDIV: begin
                reg_write = md_done;
                pc_write  = md_done;
                done      = md_done;
            end
            ST_INTR: begin
                int_taken = 1'b1;
                pc_write  = 1'b1;
                next      = ST_FETCH;
            end
            default: next = ST_INIT;
        endcase
        if (done) next = (INTR_EN != 0 && intr) ? ST_INTR : ST_FETCH;
    end
endmodule

// File: tb/tb_cu_fsm_gen2.sv
// tb_cu_fsm_gen2: randomized instruction-level check of three cu_fsm_gen2 configurations
module tb_cu_fsm_gen2;
    localparam int HS   [3] = '{0, 1, 0};
    localparam int LAT  [3] = '{2, 0, 0};
    localparam int IEN  [3] = '{1, 0, 1};
    localparam int MDEN [3] = '{1, 0, 0};

    localparam logic [9:0] PW = 10'h200, RW = 10'h100, R1 = 10'h080, R2 = 10'h040, WE = 10'h020;
    localparam logic [9:0] CSR = 10'h010, IT = 10'h008, MRET = 10'h004, MS = 10'h002, RO = 10'h001;

    localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, BRANCH = 7'b1100011;
    localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111, JALR = 7'b1100111;
    localparam logic [6:0] OPIMM = 7'b0010011, OP = 7'b0110011, SYSTEM = 7'b1110011, FENCE = 7'b0001111;

    logic       CLK = 1'b0, RST_N = 1'b0;
    logic [6:0] opcode = '0, func7 = '0;
    logic [2:0] func3 = '0;
    logic       intr = 1'b0, mem_rdy = 1'b0, md_done = 1'b0;
    logic [2:0] pc_write, reg_write, mem_rden1, mem_rden2, mem_we2, csr_we, int_taken, mret_exec, md_start, rst_out;
    int         total = 0, bad = 0, cur = 0;

    always #5 CLK = ~CLK;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        cu_fsm_gen2 #(.MEM_HS(HS[g]), .MEM_LAT(LAT[g]), .INTR_EN(IEN[g]), .MULDIV_EN(MDEN[g])) dut (
            .CLK(CLK), .RST_N(RST_N), .opcode(opcode), .func3(func3), .func7(func7),
            .intr(intr), .mem_rdy(mem_rdy), .md_done(md_done),
            .pc_write(pc_write[g]), .reg_write(reg_write[g]), .mem_rden1(mem_rden1[g]),
            .mem_rden2(mem_rden2[g]), .mem_we2(mem_we2[g]), .csr_we(csr_we[g]),
            .int_taken(int_taken[g]), .mret_exec(mret_exec[g]), .md_start(md_start[g]),
            .rst_out(rst_out[g])
        );
    end

    function automatic logic [9:0] outs(int i);
        return {pc_write[i], reg_write[i], mem_rden1[i], mem_rden2[i], mem_we2[i],
                csr_we[i], int_taken[i], mret_exec[i], md_start[i], rst_out[i]};
    endfunction

    task automatic check(string tag, logic [9:0] got, logic [9:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s dut=%0d t=%0t got=%h exp=%h", tag, cur, $time, got, exp);
        end
    endtask

    task automatic cyc(int i, string tag, logic [9:0] exp);
        #1 check(tag, outs(i), exp);
        @(negedge CLK);
    endtask

    function automatic logic [9:0] exec_exp(logic [6:0] op, logic [2:0] f3);
        if (op == SYSTEM) return (f3 == 3'b000) ? (MRET | PW) : (CSR | RW | PW);
        if (op == LUI || op == AUIPC || op == JAL || op == JALR || op == OPIMM || op == OP) return RW | PW;
        return PW;
    endfunction

    // A waiting phase lasts until its own completion event; every other handshake input is noise
    task automatic phase(int i, string tag, bit md, logic [9:0] held, logic [9:0] fin, output bit ti);
        bit r, d;
        ti = 1'b0;
        for (int n = 0; n < 40; n++) begin
            r       = ($urandom_range(0, 2) == 0) || n >= 6;
            mem_rdy = md ? 1'($urandom_range(0, 1)) : r;
            md_done = md ? r : 1'($urandom_range(0, 1));
            intr    = 1'($urandom_range(0, 1));
            d       = md ? r : (HS[i] != 0 ? r : n == LAT[i]);
            ti      = intr && IEN[i] != 0;
            cyc(i, tag, d ? fin : held);
            if (d) return;
        end
    endtask

    task automatic one(int i, string tag, logic [9:0] exp, output bit ti);
        mem_rdy = 1'($urandom_range(0, 1));
        md_done = 1'($urandom_range(0, 1));
        intr    = 1'($urandom_range(0, 1));
        ti      = intr && IEN[i] != 0;
        cyc(i, tag, exp);
    endtask

    task automatic run(int i, logic [6:0] op, logic [2:0] f3, logic [6:0] f7);
        bit ti;
        opcode = op; func3 = f3; func7 = f7;
        phase(i, "fetch", 1'b0, R1, R1, ti);
        if (op == LOAD) begin
            one(i, "ld_exec", R2, ti);
            phase(i, "ld_wb", 1'b0, RW, RW | PW, ti);
        end else if (op == STORE) begin
            phase(i, "st_exec", 1'b0, WE, WE | PW, ti);
        end else if (MDEN[i] != 0 && op == OP && f7 == 7'b0000001) begin
            one(i, "md_start", MS, ti);
            phase(i, "md_wait", 1'b1, 10'h000, RW | PW, ti);
        end else begin
            one(i, "exec", exec_exp(op, f3), ti);
        end
        if (ti) begin
            intr = 1'($urandom_range(0, 1));
            cyc(i, "intr", IT | PW);
        end
    endtask

    task automatic do_reset(int i);
        RST_N = 1'b0; intr = 1'b0; mem_rdy = 1'b0; md_done = 1'b0;
        #1 check("rst_low", outs(i), RO);
        @(negedge CLK);
        RST_N = 1'b1;
        cyc(i, "init", RO);
    endtask

    task automatic abort_load(int i);
        bit ti;
        opcode = LOAD; func3 = 3'b010; func7 = '0;
        phase(i, "ab_fetch", 1'b0, R1, R1, ti);
        one(i, "ab_exec", R2, ti);
        mem_rdy = 1'b0; intr = 1'b0;
        cyc(i, "ab_wb", RW);
        RST_N = 1'b0;
        #1 check("ab_rst", outs(i), RO);
        @(negedge CLK);
        RST_N = 1'b1;
        cyc(i, "ab_init", RO);
    endtask

    initial begin
        logic [6:0] ops [12];
        logic [6:0] f7s [3];
        logic [6:0] op;
        ops = '{LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR, OPIMM, OP, SYSTEM, FENCE, 7'b1111111};
        f7s = '{7'b0000000, 7'b0000001, 7'b0100000};
        @(negedge CLK);
        for (int i = 0; i < 3; i++) begin
            cur = i;
            do_reset(i);
            run(i, OPIMM, 3'b000, 7'b0000000);
            run(i, LOAD, 3'b010, 7'b0000000);
            run(i, STORE, 3'b010, 7'b0000000);
            run(i, OP, 3'b000, 7'b0000001);
            run(i, OP, 3'b000, 7'b0000000);
            run(i, SYSTEM, 3'b000, 7'b0000000);
            run(i, SYSTEM, 3'b001, 7'b0000000);
            if (!(HS[i] == 0 && LAT[i] == 0)) abort_load(i);
            for (int k = 0; k < 60; k++) begin
                op = ops[$urandom_range(0, 11)];
                if (op == 7'b1111111) op = 7'($urandom);
                run(i, op, 3'($urandom), f7s[$urandom_range(0, 2)]);
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
